// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared encodings and constants for the pong match sequencer
// Purpose: FSM state encoding, WINNER codes, score width and the ball centre
//          position shared with the game datapath.
// Ports:   none (package).
package pong_pkg;

    localparam int SCORE_W  = 4;
    localparam int CENTRE_X = 80;
    localparam int CENTRE_Y = 60;

    typedef logic [SCORE_W-1:0] score_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE  = 3'd1,
        PLAY   = 3'd2,
        GOAL   = 3'd3,
        OVER   = 3'd4,
        PAUSED = 3'd5
    } pongState_t;

    typedef enum logic [1:0] {
        WIN_NONE   = 2'b00,
        WIN_PLAYER = 2'b01,
        WIN_COM    = 2'b10
    } winner_t;

endpackage

// File: rtl/pong_match_sequencer_if.sv
// rtl/pong_match_sequencer_if.sv - control/status bundle between game sequencer and its environment
// Purpose: groups the sequencer's frame/button/goal inputs and its game outputs.
// Ports:   FRAME_TICK, START, PAUSE, GOAL_LEFT, GOAL_RIGHT (to sequencer);
//          GAME_EN, BALL_RESET, SCORE_P, SCORE_C, STATE, WINNER (from sequencer).
//          master = environment side, slave = sequencer side.
interface pong_match_sequencer_if;
    import pong_pkg::*;

    logic       FRAME_TICK;
    logic       START;
    logic       PAUSE;
    logic       GOAL_LEFT;
    logic       GOAL_RIGHT;
    logic       GAME_EN;
    logic       BALL_RESET;
    score_t     SCORE_P;
    score_t     SCORE_C;
    logic [2:0] STATE;
    logic [1:0] WINNER;

    modport master (
        output FRAME_TICK, START, PAUSE, GOAL_LEFT, GOAL_RIGHT,
        input  GAME_EN, BALL_RESET, SCORE_P, SCORE_C, STATE, WINNER
    );

    modport slave (
        input  FRAME_TICK, START, PAUSE, GOAL_LEFT, GOAL_RIGHT,
        output GAME_EN, BALL_RESET, SCORE_P, SCORE_C, STATE, WINNER
    );

endinterface

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - registered rising-edge detector for a level button input
// Purpose: btnRise is high while btnIn is high and its previous registered sample was low.
// Ports:   GAME_CLK (clock), RST_N (async active-low reset), btnIn (level), btnRise (pulse).
module btn_edge (
    input  logic GAME_CLK,
    input  logic RST_N,
    input  logic btnIn,
    output logic btnRise
);

    logic btnPrev;

    always_ff @(posedge GAME_CLK or negedge RST_N) begin
        if (!RST_N) btnPrev <= 1'b0;
        else        btnPrev <= btnIn;
    end

    assign btnRise = btnIn & ~btnPrev;

endmodule

// File: rtl/pong_match_sequencer.sv
// rtl/pong_match_sequencer.sv - match-level FSM for pong: serve, play, scoring, game over
// Purpose: sequences IDLE/SERVE/PLAY/GOAL/OVER, divides FRAME_TICK into GAME_EN steps,
//          keeps scores and declares the winner. Optional pause: define PONG_PAUSE_EN.
// Ports:   GAME_CLK (clock), RST_N (async active-low reset), bus (pong_match_sequencer_if.slave).
module pong_match_sequencer
    import pong_pkg::*;
#(
    parameter int TICK_DIV     = 1,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic                         GAME_CLK,
    input  logic                         RST_N,
    pong_match_sequencer_if.slave        bus
);

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [3:0] DIV_LAST   = 4'(TICK_DIV - 1);
    localparam score_t     WIN        = score_t'(WIN_SCORE);

    pongState_t state, stateNext;
    score_t     scoreP, scorePNext, scoreC, scoreCNext;
    winner_t    winner, winnerNext;
    logic [7:0] frameCnt, frameCntNext;
    logic [3:0] divCnt, divCntNext;
    logic       gameEn, gameEnNext;
    logic       startRise, pauseRise;

    btn_edge uStartEdge (.GAME_CLK(GAME_CLK), .RST_N(RST_N), .btnIn(bus.START), .btnRise(startRise));
    btn_edge uPauseEdge (.GAME_CLK(GAME_CLK), .RST_N(RST_N), .btnIn(bus.PAUSE), .btnRise(pauseRise));

`ifndef PONG_PAUSE_EN
    logic unusedPauseRise;
    assign unusedPauseRise = pauseRise;
`endif

    always_ff @(posedge GAME_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            scoreP   <= '0;
            scoreC   <= '0;
            winner   <= WIN_NONE;
            frameCnt <= '0;
            divCnt   <= '0;
            gameEn   <= 1'b0;
        end else begin
            state    <= stateNext;
            scoreP   <= scorePNext;
            scoreC   <= scoreCNext;
            winner   <= winnerNext;
            frameCnt <= frameCntNext;
            divCnt   <= divCntNext;
            gameEn   <= gameEnNext;
        end
    end

    always_comb begin
        stateNext    = state;
        scorePNext   = scoreP;
        scoreCNext   = scoreC;
        winnerNext   = winner;
        frameCntNext = frameCnt;
        divCntNext   = divCnt;
        gameEnNext   = 1'b0;

        case (state)
            IDLE, OVER: begin
                if (startRise) begin
                    scorePNext   = '0;
                    scoreCNext   = '0;
                    winnerNext   = WIN_NONE;
                    frameCntNext = '0;
                    divCntNext   = '0;
                    stateNext    = SERVE;
                end
            end
            SERVE: begin
                if (bus.FRAME_TICK) begin
                    if (frameCnt == SERVE_LAST) begin
                        frameCntNext = '0;
                        stateNext    = PLAY;
                    end else begin
                        frameCntNext = frameCnt + 8'd1;
                    end
                end
            end
            PLAY: begin
                // A goal outranks both the divider step and a pause request; the
                // divider restarts so every rally begins with a full step period.
                if (bus.GOAL_LEFT || bus.GOAL_RIGHT) begin
                    if (bus.GOAL_LEFT) scoreCNext = scoreC + score_t'(1);
                    else               scorePNext = scoreP + score_t'(1);
                    divCntNext = '0;
                    stateNext  = GOAL;
`ifdef PONG_PAUSE_EN
                end else if (pauseRise) begin
                    // The tick in the pausing cycle is dropped so no GAME_EN lands in PAUSED.
                    stateNext = PAUSED;
`endif
                end else if (bus.FRAME_TICK) begin
                    if (divCnt == DIV_LAST) begin
                        divCntNext = '0;
                        gameEnNext = 1'b1;
                    end else begin
                        divCntNext = divCnt + 4'd1;
                    end
                end
            end
            GOAL: begin
                if (scoreP == WIN) begin
                    winnerNext = WIN_PLAYER;
                    stateNext  = OVER;
                end else if (scoreC == WIN) begin
                    winnerNext = WIN_COM;
                    stateNext  = OVER;
                end else begin
                    stateNext = SERVE;
                end
            end
`ifdef PONG_PAUSE_EN
            PAUSED: begin
                if (pauseRise) stateNext = PLAY;
            end
`endif
            default: stateNext = IDLE;
        endcase
    end

    assign bus.GAME_EN    = gameEn;
`ifdef PONG_PAUSE_EN
    assign bus.BALL_RESET = (state != PLAY) && (state != PAUSED);
`else
    assign bus.BALL_RESET = (state != PLAY);
`endif
    assign bus.SCORE_P    = scoreP;
    assign bus.SCORE_C    = scoreC;
    assign bus.STATE      = state;
    assign bus.WINNER     = winner;

endmodule

// File: tb/tb_pong_match_sequencer.sv
// tb/tb_pong_match_sequencer.sv - directed self-checking bench for pong_match_sequencer
module tb_pong_match_sequencer;
    import pong_pkg::*;

    logic GAME_CLK = 1'b0;
    logic RST_N    = 1'b0;
    always #5 GAME_CLK = ~GAME_CLK;

    pong_match_sequencer_if bus();

    pong_match_sequencer #(
        .TICK_DIV(2),
        .SERVE_FRAMES(3),
        .WIN_SCORE(3)
    ) dut (
        .GAME_CLK(GAME_CLK),
        .RST_N(RST_N),
        .bus(bus)
    );

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int enSeen   = 0;
    int enPushed = 0;
    int expEn[$];

    always @(posedge GAME_CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every GAME_EN pulse must match the cycle queued when its terminal tick was driven.
    always @(negedge GAME_CLK) begin
        if (bus.GAME_EN !== 1'b0) begin
            enSeen++;
            if (expEn.size() == 0) check("game_en_unexpected", 32'(bus.GAME_EN), 32'd0);
            else                   check("game_en_cycle", cyc, expEn.pop_front());
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge GAME_CLK);
    endtask

    task automatic tick(input bit terminal);
        @(negedge GAME_CLK);
        bus.FRAME_TICK = 1'b1;
        if (terminal) begin
            expEn.push_back(cyc + 1);
            enPushed++;
        end
        @(negedge GAME_CLK);
        bus.FRAME_TICK = 1'b0;
        @(negedge GAME_CLK);
    endtask

    task automatic serve();
        repeat (3) tick(1'b0);
    endtask

    task automatic goal(input bit left, input bit right);
        @(negedge GAME_CLK);
        bus.GOAL_LEFT  = left;
        bus.GOAL_RIGHT = right;
        @(negedge GAME_CLK);
        bus.GOAL_LEFT  = 1'b0;
        bus.GOAL_RIGHT = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge GAME_CLK);
        bus.START = 1'b1;
        @(negedge GAME_CLK);
        bus.START = 1'b0;
    endtask

    task automatic pulse_pause();
        @(negedge GAME_CLK);
        bus.PAUSE = 1'b1;
        @(negedge GAME_CLK);
        bus.PAUSE = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_state"},      32'(bus.STATE),      32'd0);
        check({pfx, "_game_en"},    32'(bus.GAME_EN),    32'd0);
        check({pfx, "_ball_reset"}, 32'(bus.BALL_RESET), 32'd1);
        check({pfx, "_score_p"},    32'(bus.SCORE_P),    32'd0);
        check({pfx, "_score_c"},    32'(bus.SCORE_C),    32'd0);
        check({pfx, "_winner"},     32'(bus.WINNER),     32'd0);
    endtask

    initial begin
        bus.FRAME_TICK = 1'b0;
        bus.START      = 1'b0;
        bus.PAUSE      = 1'b0;
        bus.GOAL_LEFT  = 1'b0;
        bus.GOAL_RIGHT = 1'b0;

        idle(2);
        check_reset_outputs("reset");
        @(negedge GAME_CLK);
        RST_N = 1'b1;
        idle(1);
        check("idle_after_reset", 32'(bus.STATE), 32'd0);

        // START rise -> SERVE, three frames -> PLAY
        pulse_start();
        check("start_to_serve", 32'(bus.STATE), 32'd1);
        check("serve_ball_reset", 32'(bus.BALL_RESET), 32'd1);
        tick(1'b0);
        tick(1'b0);
        check("serve_after_2_ticks", 32'(bus.STATE), 32'd1);
        tick(1'b0);
        check("serve_to_play", 32'(bus.STATE), 32'd2);
        check("play_ball_reset", 32'(bus.BALL_RESET), 32'd0);

        // Six ticks in PLAY -> GAME_EN after ticks 2, 4, 6
        for (int i = 1; i <= 6; i++) tick(i % 2 == 0);
        idle(2);
        check("div_pulse_count", enSeen, 32'd3);
        check("div_queue_drained", expEn.size(), 32'd0);

        // Player wins 3-0
        for (int k = 1; k <= 3; k++) begin
            goal(1'b0, 1'b1);
            check("goal_state", 32'(bus.STATE), 32'd3);
            check("goal_score_p", 32'(bus.SCORE_P), 32'(k));
            idle(1);
            if (k < 3) begin
                check("goal_to_serve", 32'(bus.STATE), 32'd1);
                serve();
                check("reserve_to_play", 32'(bus.STATE), 32'd2);
            end
        end
        check("over_state", 32'(bus.STATE), 32'd4);
        check("over_winner", 32'(bus.WINNER), 32'd1);
        check("over_ball_reset", 32'(bus.BALL_RESET), 32'd1);

        // Goals ignored outside PLAY
        goal(1'b1, 1'b0);
        idle(1);
        check("over_goal_ignored", 32'(bus.SCORE_C), 32'd0);
        check("over_held", 32'(bus.STATE), 32'd4);
        check("over_score_held", 32'(bus.SCORE_P), 32'd3);

        // New match
        pulse_start();
        check("restart_state", 32'(bus.STATE), 32'd1);
        check("restart_score_p", 32'(bus.SCORE_P), 32'd0);
        check("restart_winner", 32'(bus.WINNER), 32'd0);
        serve();
        check("restart_play", 32'(bus.STATE), 32'd2);

        // Both goals on the terminal tick: left wins, no GAME_EN
        tick(1'b0);
        @(negedge GAME_CLK);
        bus.FRAME_TICK = 1'b1;
        bus.GOAL_LEFT  = 1'b1;
        bus.GOAL_RIGHT = 1'b1;
        @(negedge GAME_CLK);
        bus.FRAME_TICK = 1'b0;
        bus.GOAL_LEFT  = 1'b0;
        bus.GOAL_RIGHT = 1'b0;
        check("dual_goal_state", 32'(bus.STATE), 32'd3);
        check("dual_goal_score_c", 32'(bus.SCORE_C), 32'd1);
        check("dual_goal_score_p", 32'(bus.SCORE_P), 32'd0);
        idle(3);
        check("dual_goal_to_serve", 32'(bus.STATE), 32'd1);

        goal(1'b0, 1'b1);
        idle(1);
        check("serve_goal_ignored", 32'(bus.SCORE_P), 32'd0);

        serve();
        goal(1'b1, 1'b0);
        check("com_second_goal", 32'(bus.SCORE_C), 32'd2);
        idle(1);
        serve();
        check("play_with_c2", 32'(bus.STATE), 32'd2);

`ifdef PONG_PAUSE_EN
        pulse_pause();
        check("paused_state", 32'(bus.STATE), 32'd5);
        check("paused_ball_reset", 32'(bus.BALL_RESET), 32'd0);
        repeat (5) tick(1'b0);
        goal(1'b1, 1'b0);
        idle(1);
        check("paused_state_held", 32'(bus.STATE), 32'd5);
        check("paused_score_c", 32'(bus.SCORE_C), 32'd2);
        check("paused_score_p", 32'(bus.SCORE_P), 32'd0);
        pulse_pause();
        check("resume_play", 32'(bus.STATE), 32'd2);
        tick(1'b0);
        tick(1'b1);
        idle(2);
        check("resume_queue_drained", expEn.size(), 32'd0);
`else
        pulse_pause();
        idle(1);
        check("pause_ignored", 32'(bus.STATE), 32'd2);
`endif

        // Asynchronous reset mid-match with SCORE_C=2
        tick(1'b0);
        @(negedge GAME_CLK);
        #2 RST_N = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        idle(3);
        check("reset_held_state", 32'(bus.STATE), 32'd0);
        @(negedge GAME_CLK);
        RST_N = 1'b1;
        idle(3);
        check("post_reset_idle", 32'(bus.STATE), 32'd0);
        check("game_en_total", enSeen, enPushed);
        check("final_queue_drained", expEn.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
